// File: rtl/anton_neopixel_stream_seq_pkg.sv
// ============================================================================
// Module   : anton_neopixel_stream_seq_pkg
// Brief    : Shared defaults, state encoding and helpers for the NeoPixel
//            stream sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package anton_neopixel_stream_seq_pkg;

    localparam int BUFFER_END_DEFAULT    = 255;
    localparam int RESET_DELAY_DEFAULT   = 320;
    localparam int PATTERN_STEPS_DEFAULT = 8;
    localparam int BITS_RGB              = 24;
    localparam int BITS_RGBW             = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRANSMIT = 2'd1,
        ST_RESET    = 2'd2,
        ST_DONE     = 2'd3
    } stream_state_e;

    function automatic logic [4:0] last_bit(input logic rgbw);
        return rgbw ? 5'(BITS_RGBW - 1) : 5'(BITS_RGB - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/anton_neopixel_stream_seq_reset_timer.sv
// ============================================================================
// Module   : anton_neopixel_reset_timer
// Brief    : Reset-gap counter with programmable delay and sync pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anton_neopixel_reset_timer #(
    parameter int RESET_DELAY = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        in_reset_i,
    input  logic        count_en_i,
    input  logic        advance_i,
    input  logic [11:0] reset_delay_i,
    output logic        sync_o
);

    logic [11:0] count_q;
    logic [11:0] count_d;
    logic [11:0] delay;

    assign delay  = (reset_delay_i == 12'd0) ? 12'(RESET_DELAY) : reset_delay_i;
    assign sync_o = in_reset_i && (count_q == delay);

    // The gap completes and restarts on the same edge the FSM leaves RESET.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 12'd0;
        end else if (sync_o && advance_i) begin
            count_d = 12'd0;
        end else if (count_en_i) begin
            count_d = count_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 12'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/anton_neopixel_stream_seq.sv
// ============================================================================
// Module   : anton_neopixel_stream_seq
// Brief    : NeoPixel stream sequencer: sub-bit/bit/pixel indices and
//            transmit/reset framing for one LED chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anton_neopixel_stream_seq
    import anton_neopixel_stream_seq_pkg::*;
#(
    parameter int  BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int  RESET_DELAY   = RESET_DELAY_DEFAULT,
    parameter int  PATTERN_STEPS = PATTERN_STEPS_DEFAULT,
    localparam int BUFFER_BITS   = $clog2(BUFFER_END + 1),
    localparam int PATTERN_BITS  = $clog2(PATTERN_STEPS)
) (
    input  logic                    clk6_4mhz,
    input  logic                    rst,
    input  logic                    regCtrlInit,
    input  logic                    regCtrlRun,
    input  logic                    regCtrlLoop,
    input  logic                    regCtrlLimit,
    input  logic                    regCtrl32bit,
    input  logic                    regCtrlRgbw,
    input  logic [12:0]             regMax,
    input  logic [11:0]             regResetDelay,
    input  logic                    initSlow,
    output logic                    initSlowDone,
    output logic [PATTERN_BITS-1:0] bitPatternIndex,
    output logic [4:0]              pixelBitIndex,
    output logic [BUFFER_BITS-1:0]  pixelIndex,
    output logic [BUFFER_BITS-1:0]  pixelIndexMax,
    output logic [1:0]              state,
    output logic                    streamOutput,
    output logic                    streamReset,
    output logic                    streamBitOf,
    output logic                    streamPixelOf,
    output logic                    streamSyncOf,
    output logic                    streamDone
);

    stream_state_e           state_q, state_d;
    logic [PATTERN_BITS-1:0] pat_q, pat_d;
    logic [4:0]              bit_q, bit_d;
    logic [BUFFER_BITS-1:0]  pix_q, pix_d;
    logic                    done_q, done_d;

    logic                    active;
    logic                    pat_of;
    logic                    last_px;
    logic                    sync_of;
    logic [4:0]              last_bit_w;
    logic [BUFFER_BITS-1:0]  equiv;
    logic [BUFFER_BITS-1:0]  step;

    assign active        = !regCtrlInit && regCtrlRun;
    assign streamOutput  = active && (state_q == ST_TRANSMIT);
    assign streamReset   = active && (state_q == ST_RESET);
    assign streamDone    = (state_q == ST_DONE);
    assign streamSyncOf  = sync_of;
    assign state         = state_q;

    assign pat_of        = streamOutput && (pat_q == PATTERN_BITS'(PATTERN_STEPS - 1));
    assign last_bit_w    = last_bit(regCtrlRgbw);
    assign streamBitOf   = pat_of && (bit_q == last_bit_w);

    // Word-aligned pixels compare their last byte against the limit.
    assign equiv         = regCtrl32bit ? {pix_q[BUFFER_BITS-1:2], 2'b11} : pix_q;
    assign pixelIndexMax = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUFFER_BITS'(BUFFER_END);
    assign last_px       = equiv >= pixelIndexMax;
    assign streamPixelOf = streamBitOf && last_px;
    assign step          = regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);

    assign bitPatternIndex = pat_q;
    assign pixelBitIndex   = bit_q;
    assign pixelIndex      = pix_q;
    assign initSlowDone    = done_q;

    if (BUFFER_BITS < 13) begin : g_regmax_unused
        logic unused_regmax;
        assign unused_regmax = ^regMax[12:BUFFER_BITS];
    end

    anton_neopixel_reset_timer #(
        .RESET_DELAY (RESET_DELAY)
    ) u_reset_timer (
        .clk           (clk6_4mhz),
        .rst           (rst),
        .clear_i       (regCtrlInit),
        .in_reset_i    (state_q == ST_RESET),
        .count_en_i    (streamReset),
        .advance_i     (active),
        .reset_delay_i (regResetDelay),
        .sync_o        (sync_of)
    );

    always_comb begin
        state_d = state_q;
        if (regCtrlInit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (active) state_d = ST_TRANSMIT;
                ST_TRANSMIT: if (streamPixelOf) state_d = ST_RESET;
                ST_RESET:    if (sync_of && active) state_d = regCtrlLoop ? ST_TRANSMIT : ST_DONE;
                ST_DONE:     if (!regCtrlRun) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // An out-of-range bit index (mid-frame RGBW change) still wraps at 31.
    always_comb begin
        pat_d  = pat_q;
        bit_d  = bit_q;
        pix_d  = pix_q;
        done_d = 1'b0;
        if (initSlow) begin
            pat_d  = '0;
            bit_d  = '0;
            pix_d  = '0;
            done_d = !done_q;
        end else begin
            if (streamOutput) pat_d = pat_q + PATTERN_BITS'(1);
            if (pat_of)       bit_d = (bit_q == last_bit_w) ? 5'd0 : bit_q + 5'd1;
            if (streamBitOf)  pix_d = last_px ? '0 : pix_q + step;
        end
    end

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_stream_seq.sv
// ============================================================================
// Module   : tb_anton_neopixel_stream_seq
// Brief    : Self-checking bench for the NeoPixel stream sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anton_neopixel_stream_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regCtrlInit = 1'b0, regCtrlRun = 1'b0, regCtrlLoop = 1'b0;
    logic        regCtrlLimit = 1'b0, regCtrl32bit = 1'b0, regCtrlRgbw = 1'b0;
    logic [12:0] regMax = '0;
    logic [11:0] regResetDelay = '0;
    logic        initSlow = 1'b0;
    logic        initSlowDone;
    logic [2:0]  bitPatternIndex;
    logic [4:0]  pixelBitIndex;
    logic [7:0]  pixelIndex, pixelIndexMax;
    logic [1:0]  state;
    logic        streamOutput, streamReset, streamBitOf, streamPixelOf, streamSyncOf, streamDone;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit sb_en = 1'b0;
    int act_cnt, pof_cnt, bitmax;

    typedef struct {
        bit rgbw; bit b32; bit limit;
        int max; int delay;
        int cyc; int gap; int bmax; int pmax;
    } vec_t;
    vec_t vecs[5];

    anton_neopixel_stream_seq #(
        .BUFFER_END    (255),
        .RESET_DELAY   (320),
        .PATTERN_STEPS (8)
    ) dut (
        .clk6_4mhz       (clk),
        .rst             (rst),
        .regCtrlInit     (regCtrlInit),
        .regCtrlRun      (regCtrlRun),
        .regCtrlLoop     (regCtrlLoop),
        .regCtrlLimit    (regCtrlLimit),
        .regCtrl32bit    (regCtrl32bit),
        .regCtrlRgbw     (regCtrlRgbw),
        .regMax          (regMax),
        .regResetDelay   (regResetDelay),
        .initSlow        (initSlow),
        .initSlowDone    (initSlowDone),
        .bitPatternIndex (bitPatternIndex),
        .pixelBitIndex   (pixelBitIndex),
        .pixelIndex      (pixelIndex),
        .pixelIndexMax   (pixelIndexMax),
        .state           (state),
        .streamOutput    (streamOutput),
        .streamReset     (streamReset),
        .streamBitOf     (streamBitOf),
        .streamPixelOf   (streamPixelOf),
        .streamSyncOf    (streamSyncOf),
        .streamDone      (streamDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each bit-overflow pops the pixel index the bench expects next.
    always @(negedge clk) begin
        if (sb_en) begin
            if (streamOutput) begin
                act_cnt++;
                if (int'(pixelBitIndex) > bitmax) bitmax = int'(pixelBitIndex);
            end
            if (streamPixelOf) pof_cnt++;
            if (streamBitOf) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_pixel", int'(pixelIndex), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit limit, input bit b32, input int max);
        int p  = 0;
        int mx = limit ? max : 255;
        for (int n = 0; n < 300; n++) begin
            int eq = b32 ? (p | 3) : p;
            exp_q.push_back(p);
            if (eq >= mx) break;
            p = (p + (b32 ? 4 : 1)) & 255;
        end
    endtask

    task automatic clr_counts();
        act_cnt = 0; pof_cnt = 0; bitmax = 0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    task automatic cfg(input bit rgbw, input bit b32, input bit limit, input int max,
                       input int delay, input bit loop);
        regCtrlRgbw = rgbw; regCtrl32bit = b32; regCtrlLimit = limit;
        regMax = 13'(max); regResetDelay = 12'(delay); regCtrlLoop = loop;
    endtask

    // Waits for the end of TRANSMIT, checks totals, then measures the reset gap.
    task automatic frame(input int cyc, input int gap, input int bmax);
        bit ok = 1'b0;
        int g = 0;
        for (int n = 0; n < 20000; n++) begin
            tick();
            if (state == 2'd2) begin ok = 1'b1; break; end
        end
        chk("reach_reset", int'(ok), 1);
        chk("active_cycles", act_cnt, cyc);
        chk("pixel_of_count", pof_cnt, 1);
        chk("bit_index_max", bitmax, bmax);
        while (!streamSyncOf && g < 5000) begin
            tick();
            g++;
        end
        chk("reset_gap", g, gap);
        tick();
    endtask

    initial begin
        vecs[0] = '{rgbw:0, b32:0, limit:1, max:2, delay:10, cyc:576,   gap:10,  bmax:23, pmax:2};
        vecs[1] = '{rgbw:1, b32:1, limit:1, max:7, delay:10, cyc:512,   gap:10,  bmax:31, pmax:7};
        vecs[2] = '{rgbw:0, b32:0, limit:1, max:0, delay:1,  cyc:192,   gap:1,   bmax:23, pmax:0};
        vecs[3] = '{rgbw:0, b32:1, limit:1, max:5, delay:0,  cyc:384,   gap:320, bmax:23, pmax:5};
        vecs[4] = '{rgbw:0, b32:1, limit:0, max:0, delay:7,  cyc:12288, gap:7,   bmax:23, pmax:255};

        tick();
        chk("rst_state", int'(state), 0);
        chk("rst_pixel", int'(pixelIndex), 0);
        chk("rst_bit", int'(pixelBitIndex), 0);
        chk("rst_pat", int'(bitPatternIndex), 0);
        chk("rst_outputs", int'({initSlowDone, streamOutput, streamReset, streamSyncOf, streamDone}), 0);
        rst = 1'b0;

        // One-shot frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            cfg(vecs[i].rgbw, vecs[i].b32, vecs[i].limit, vecs[i].max, vecs[i].delay, 1'b0);
            exp_q.delete();
            push_exp(vecs[i].limit, vecs[i].b32, vecs[i].max);
            clr_counts();
            sb_en = 1'b1;
            regCtrlRun = 1'b1;
            #1 chk("pixel_index_max", int'(pixelIndexMax), vecs[i].pmax);
            frame(vecs[i].cyc, vecs[i].gap, vecs[i].bmax);
            chk("sb_drained", exp_q.size(), 0);
            chk("done_state", int'(state), 3);
            chk("stream_done", int'(streamDone), 1);
            regCtrlRun = 1'b0;
            tick();
            chk("idle_after_run_off", int'(state), 0);
            sb_en = 1'b0;
        end

        // Loop mode with the default gap: three frames back to back.
        do_reset();
        cfg(0, 0, 1, 2, 0, 1'b1);
        exp_q.delete();
        for (int f = 0; f < 3; f++) push_exp(1'b1, 1'b0, 2);
        sb_en = 1'b1;
        regCtrlRun = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clr_counts();
            frame(576, 320, 23);
            chk("loop_restart_state", int'(state), 1);
            chk("loop_restart_pixel", int'(pixelIndex), 0);
        end
        regCtrlInit = 1'b1;
        tick();
        chk("init_forces_idle", int'(state), 0);
        regCtrlInit = 1'b0; regCtrlRun = 1'b0; sb_en = 1'b0;

        // Run dropped at pixel 1, bit 5: indices freeze, frame completes on resume.
        do_reset();
        cfg(0, 0, 1, 2, 10, 1'b0);
        exp_q.delete();
        push_exp(1'b1, 1'b0, 2);
        clr_counts();
        sb_en = 1'b1;
        regCtrlRun = 1'b1;
        begin
            bit ok = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                tick();
                if (pixelIndex == 8'd1 && pixelBitIndex == 5'd5 && bitPatternIndex == 3'd0) begin
                    ok = 1'b1; break;
                end
            end
            chk("reach_pause_point", int'(ok), 1);
        end
        regCtrlRun = 1'b0;
        repeat (20) tick();
        chk("freeze_pixel", int'(pixelIndex), 1);
        chk("freeze_bit", int'(pixelBitIndex), 5);
        chk("freeze_pat", int'(bitPatternIndex), 0);
        chk("freeze_state", int'(state), 1);
        chk("freeze_output", int'(streamOutput), 0);
        chk("freeze_active_cycles", act_cnt, 232);
        regCtrlRun = 1'b1;
        frame(576, 10, 23);
        chk("resume_done", int'(state), 3);
        regCtrlRun = 1'b0; sb_en = 1'b0;

        // Asynchronous reset in the middle of the reset gap.
        do_reset();
        cfg(0, 0, 1, 2, 10, 1'b0);
        regCtrlRun = 1'b1;
        begin
            bit ok = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                tick();
                if (state == 2'd2) begin ok = 1'b1; break; end
            end
            chk("reach_reset_gap", int'(ok), 1);
        end
        tick(); tick();
        chk("in_reset_gap", int'(streamReset), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_outputs", int'({streamOutput, streamReset, streamSyncOf, streamDone}), 0);
        #1 rst = 1'b0;

        // initSlow at bit 12 clears the indices and acknowledges once.
        cfg(0, 0, 1, 2, 10, 1'b0);
        begin
            bit ok = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                tick();
                if (pixelBitIndex == 5'd12 && bitPatternIndex == 3'd0) begin ok = 1'b1; break; end
            end
            chk("reach_bit12", int'(ok), 1);
        end
        initSlow = 1'b1;
        tick();
        initSlow = 1'b0;
        chk("init_slow_pixel", int'(pixelIndex), 0);
        chk("init_slow_bit", int'(pixelBitIndex), 0);
        chk("init_slow_pat", int'(bitPatternIndex), 0);
        chk("init_slow_done", int'(initSlowDone), 1);
        tick();
        chk("init_slow_done_clear", int'(initSlowDone), 0);
        chk("init_slow_resume_pat", int'(bitPatternIndex), 1);
        regCtrlRun = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
